// File: rtl/axi_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_arb_pkg
// Brief    : Shared widths, FSM state encoding and AXI encodings for the
//            AXI read-path arbiter and its interface.
// Revision : 1.0 - initial release
// ============================================================================
package axi_arb_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 8;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } axi_resp_e;

endpackage
`default_nettype wire

// File: rtl/axi_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arb_if
// Brief    : Upstream (per-master, packed) and downstream AXI read channels
//            seen by the read arbiter. The slave modport is the arbiter's
//            view; the master modport is the surrounding environment's view
//            (requesting masters plus the downstream slave).
// Revision : 1.0 - initial release
// ============================================================================
interface axi_rd_arb_if #(
  parameter int NUM_M      = 2,
  parameter int ADDR_WIDTH = axi_arb_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi_arb_pkg::DATA_WIDTH,
  parameter int ID_WIDTH   = axi_arb_pkg::ID_WIDTH
);

  // Upstream AR, master i occupies slice i
  logic [NUM_M-1:0]            m_arvalid;
  logic [NUM_M-1:0]            m_arready;
  logic [NUM_M*ID_WIDTH-1:0]   m_arid;
  logic [NUM_M*ADDR_WIDTH-1:0] m_araddr;
  logic [NUM_M*8-1:0]          m_arlen;
  logic [NUM_M*3-1:0]          m_arsize;
  logic [NUM_M*2-1:0]          m_arburst;

  // Upstream R, payload broadcast
  logic [NUM_M-1:0]            m_rvalid;
  logic [NUM_M-1:0]            m_rready;
  logic [ID_WIDTH-1:0]         m_rid;
  logic [DATA_WIDTH-1:0]       m_rdata;
  logic [1:0]                  m_rresp;
  logic                        m_rlast;

  // Downstream AR
  logic                        s_arvalid;
  logic                        s_arready;
  logic [ID_WIDTH-1:0]         s_arid;
  logic [ADDR_WIDTH-1:0]       s_araddr;
  logic [7:0]                  s_arlen;
  logic [2:0]                  s_arsize;
  logic [1:0]                  s_arburst;

  // Downstream R
  logic                        s_rvalid;
  logic                        s_rready;
  logic [ID_WIDTH-1:0]         s_rid;
  logic [DATA_WIDTH-1:0]       s_rdata;
  logic [1:0]                  s_rresp;
  logic                        s_rlast;

  modport slave (
    input  m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
    output m_arready,
    output m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
    input  m_rready,
    output s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst,
    input  s_arready,
    input  s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
    output s_rready
  );

  modport master (
    output m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
    input  m_arready,
    input  m_rvalid, m_rid, m_rdata, m_rresp, m_rlast,
    output m_rready,
    input  s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst,
    output s_arready,
    output s_rvalid, s_rid, s_rdata, s_rresp, s_rlast,
    input  s_rready
  );

endinterface
`default_nettype wire

// File: rtl/axi_rd_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. Grants the first requester at
//            or after ptr, wrapping cyclically. Outputs one-hot and index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  wire logic [N-1:0]  req,
  input  wire logic [IW-1:0] ptr,
  output logic      [N-1:0]  gnt,
  output logic      [IW-1:0] gnt_idx
);

  logic          w_found;
  int            w_pos;
  logic [IW-1:0] w_cand;

  // Scan from ptr upward, wrapping, and take the first active request
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_pos   = 0;
    w_cand  = '0;
    for (int off = 0; off < N; off++) begin
      w_pos = int'(ptr) + off;
      if (w_pos >= N) w_pos = w_pos - N;
      w_cand = IW'(w_pos);
      if (!w_found && req[w_cand]) begin
        w_found      = 1'b1;
        gnt[w_cand]  = 1'b1;
        gnt_idx      = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Brief    : Shares one AXI4 read path between NUM_M masters. Round-robin on
//            AR, grant held until the rlast beat handshakes (one burst in
//            flight), R beats counted against arlen with a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
  parameter  int NUM_M      = 2,
  parameter  int ADDR_WIDTH = axi_arb_pkg::ADDR_WIDTH,
  parameter  int DATA_WIDTH = axi_arb_pkg::DATA_WIDTH,
  parameter  int ID_WIDTH   = axi_arb_pkg::ID_WIDTH,
  localparam int GW         = $clog2(NUM_M)
) (
  input  wire logic      clk,
  input  wire logic      reset,
  axi_rd_arb_if.slave    bus,
  output logic [GW-1:0]  grant,
  output logic           busy,
  output logic           len_err
);

  import axi_arb_pkg::*;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ADDR = ADDR;
  localparam logic [1:0] S_DATA = DATA;

  logic [1:0]            r_state;
  logic [GW-1:0]         r_grant;
  logic [GW-1:0]         r_ptr;
  logic [7:0]            r_beat_cnt;
  logic                  r_len_err;

  logic [NUM_M-1:0]      w_rr_gnt;
  logic [GW-1:0]         w_rr_idx;
  logic                  w_any;
  logic [7:0]            w_arlen_win;
  logic [GW-1:0]         w_ptr_next;

  logic                  w_sel_arvalid;
  logic                  w_sel_rready;
  logic [ID_WIDTH-1:0]   w_sel_arid;
  logic [ADDR_WIDTH-1:0] w_sel_araddr;
  logic [7:0]            w_sel_arlen;
  logic [2:0]            w_sel_arsize;
  logic [1:0]            w_sel_arburst;
  logic [DATA_WIDTH-1:0] w_rdata;

  rr_arbiter #(
    .N       (NUM_M)
  ) u_rr (
    .req     (bus.m_arvalid),
    .ptr     (r_ptr),
    .gnt     (w_rr_gnt),
    .gnt_idx (w_rr_idx)
  );

  assign w_any      = |w_rr_gnt;
  assign w_ptr_next = (r_grant == GW'(NUM_M - 1)) ? '0 : r_grant + GW'(1);

  // Select the granted master's AR payload and rready, and the RR winner's arlen
  always_comb begin
    w_sel_arvalid = 1'b0;
    w_sel_rready  = 1'b0;
    w_sel_arid    = '0;
    w_sel_araddr  = '0;
    w_sel_arlen   = '0;
    w_sel_arsize  = '0;
    w_sel_arburst = '0;
    w_arlen_win   = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_grant == GW'(i)) begin
        w_sel_arvalid = bus.m_arvalid[i];
        w_sel_rready  = bus.m_rready[i];
        w_sel_arid    = bus.m_arid[i*ID_WIDTH +: ID_WIDTH];
        w_sel_araddr  = bus.m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_arlen   = bus.m_arlen[i*8 +: 8];
        w_sel_arsize  = bus.m_arsize[i*3 +: 3];
        w_sel_arburst = bus.m_arburst[i*2 +: 2];
      end
      if (w_rr_idx == GW'(i)) begin
        w_arlen_win = bus.m_arlen[i*8 +: 8];
      end
    end
  end

  // Route handshakes to/from the granted master only, gated by FSM phase
  always_comb begin
    bus.s_arvalid = (r_state == S_ADDR) && w_sel_arvalid;
    bus.s_arid    = w_sel_arid;
    bus.s_araddr  = w_sel_araddr;
    bus.s_arlen   = w_sel_arlen;
    bus.s_arsize  = w_sel_arsize;
    bus.s_arburst = w_sel_arburst;
    bus.s_rready  = (r_state == S_DATA) && w_sel_rready;
    bus.m_arready = '0;
    bus.m_rvalid  = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (r_grant == GW'(i)) begin
        bus.m_arready[i] = (r_state == S_ADDR) && bus.s_arready;
        bus.m_rvalid[i]  = (r_state == S_DATA) && bus.s_rvalid;
      end
    end
  end

  // R payload is broadcast; only the granted master sees rvalid
  assign w_rdata     = bus.s_rdata;
  assign bus.m_rdata = w_rdata;
  assign bus.m_rid   = bus.s_rid;
  assign bus.m_rresp = bus.s_rresp;
  assign bus.m_rlast = bus.s_rlast;

  // Arbitration FSM with beat counting; reset abandons any burst in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant    <= w_rr_idx;
            r_beat_cnt <= w_arlen_win;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (bus.s_arvalid && bus.s_arready) r_state <= S_DATA;
        end
        S_DATA: begin
          if (bus.s_rvalid && bus.s_rready) begin
            // Saturate at zero so an overlong burst cannot wrap the counter
            if (r_beat_cnt != 8'd0) r_beat_cnt <= r_beat_cnt - 8'd1;
            if (bus.s_rlast) begin
              if (r_beat_cnt != 8'd0) r_len_err <= 1'b1;
              r_ptr   <= w_ptr_next;
              r_state <= S_IDLE;
            end else if (r_beat_cnt == 8'd0) begin
              r_len_err <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant   = r_grant;
  assign busy    = (r_state != S_IDLE);
  assign len_err = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Brief    : Directed self-checking bench for axi_rd_arbiter (NUM_M = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

  import axi_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [0:0] grant;
  logic       busy;
  logic       len_err;

  int n_tests = 0;
  int n_fail  = 0;

  axi_rd_arb_if #(.NUM_M(2)) bus ();

  axi_rd_arbiter #(.NUM_M(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .grant   (grant),
    .busy    (busy),
    .len_err (len_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.m_arvalid = '0;
    bus.m_arid    = '0;
    bus.m_araddr  = '0;
    bus.m_arlen   = '0;
    bus.m_arsize  = '0;
    bus.m_arburst = '0;
    bus.m_rready  = '0;
    bus.s_arready = 1'b1;
    bus.s_rvalid  = 1'b0;
    bus.s_rid     = '0;
    bus.s_rdata   = '0;
    bus.s_rresp   = '0;
    bus.s_rlast   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic set_req(input int m, input logic [15:0] addr, input logic [7:0] len);
    bus.m_arvalid[m]        = 1'b1;
    bus.m_arid[m*8 +: 8]    = 8'h10 + 8'(m);
    bus.m_araddr[m*16 +: 16] = addr;
    bus.m_arlen[m*8 +: 8]   = len;
    bus.m_arsize[m*3 +: 3]  = 3'd2;
    bus.m_arburst[m*2 +: 2] = BURST_INCR;
  endtask

  // Called in IDLE with the request already driven and s_arready=1
  task automatic ar_phase(input int m, input logic [15:0] addr, input logic [7:0] len, input bit keep);
    check_val("idle_s_arvalid", bus.s_arvalid, 0);
    check_val("idle_busy", busy, 0);
    cyc();
    check_val("ar_s_arvalid", bus.s_arvalid, 1);
    check_val("ar_grant", grant, m);
    check_val("ar_araddr", bus.s_araddr, addr);
    check_val("ar_arlen", bus.s_arlen, len);
    check_val("ar_arid", bus.s_arid, 8'h10 + m);
    check_val("ar_arburst", bus.s_arburst, BURST_INCR);
    check_val("ar_m_arready", bus.m_arready, 64'(1) << m);
    cyc();
    if (!keep) bus.m_arvalid[m] = 1'b0;
    check_val("data_busy", busy, 1);
    check_val("data_s_arvalid", bus.s_arvalid, 0);
  endtask

  // Slave returns nbeats beats, rlast on the last one, master always ready
  task automatic r_phase(input int m, input int nbeats);
    bus.m_rready = '1;
    for (int k = 0; k < nbeats; k++) begin
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = 32'hA500_0000 + (m << 16) + k;
      bus.s_rlast  = (k == nbeats - 1);
      bus.s_rresp  = 2'(k);
      bus.s_rid    = 8'h10 + 8'(m);
      #1;
      check_val("r_m_rvalid", bus.m_rvalid, 64'(1) << m);
      check_val("r_m_rdata", bus.m_rdata, 32'hA500_0000 + (m << 16) + k);
      check_val("r_m_rresp", bus.m_rresp, k % 4);
      check_val("r_m_rlast", bus.m_rlast, (k == nbeats - 1));
      check_val("r_s_rready", bus.s_rready, 1);
      cyc();
    end
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
    bus.m_rready = '0;
    #1;
    check_val("r_end_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    bit rr;

    // Reset values
    reset = 1'b1;
    clear_inputs();
    bus.m_rready = '1;
    bus.s_rvalid = 1'b1;
    cyc();
    cyc();
    check_val("rst_busy", busy, 0);
    check_val("rst_grant", grant, 0);
    check_val("rst_len_err", len_err, 0);
    check_val("rst_s_arvalid", bus.s_arvalid, 0);
    check_val("rst_s_rready", bus.s_rready, 0);
    check_val("rst_m_arready", bus.m_arready, 0);
    check_val("rst_m_rvalid", bus.m_rvalid, 0);
    do_reset();

    // Single request, master0, 4 beats
    set_req(0, 16'h0100, 8'd3);
    ar_phase(0, 16'h0100, 8'd3, 1'b0);
    r_phase(0, 4);
    check_val("single_len_err", len_err, 0);

    // Simultaneous continuous requests, single-beat bursts: 0,1,0,1
    do_reset();
    set_req(0, 16'h0200, 8'd0);
    set_req(1, 16'h0300, 8'd0);
    for (int b = 0; b < 4; b++) begin
      ar_phase(b % 2, (b % 2) ? 16'h0300 : 16'h0200, 8'd0, 1'b1);
      r_phase(b % 2, 1);
    end
    bus.m_arvalid = '0;
    check_val("rr_len_err", len_err, 0);

    // AR backpressure on master1
    set_req(1, 16'h2222, 8'd0);
    bus.s_arready = 1'b0;
    cyc();
    for (int c = 0; c < 5; c++) begin
      check_val("bp_s_arvalid", bus.s_arvalid, 1);
      check_val("bp_araddr", bus.s_araddr, 16'h2222);
      check_val("bp_m_arready", bus.m_arready, 0);
      check_val("bp_grant", grant, 1);
      cyc();
    end
    bus.s_arready = 1'b1;
    #1;
    check_val("bp_m_arready_rise", bus.m_arready, 2'b10);
    cyc();
    bus.m_arvalid[1] = 1'b0;
    check_val("bp_one_hs_arvalid", bus.s_arvalid, 0);
    check_val("bp_busy", busy, 1);
    r_phase(1, 1);

    // R backpressure: master0 rready toggles 1,0,1,0...
    set_req(0, 16'h0400, 8'd3);
    ar_phase(0, 16'h0400, 8'd3, 1'b0);
    hs = 0;
    for (int c = 0; c < 12 && hs < 4; c++) begin
      rr = (c % 2 == 0);
      bus.m_rready    = '0;
      bus.m_rready[0] = rr;
      bus.s_rvalid    = 1'b1;
      bus.s_rdata     = 32'h0000_00B0 + hs;
      bus.s_rlast     = (hs == 3);
      #1;
      check_val("rbp_s_rready", bus.s_rready, rr);
      check_val("rbp_m_rvalid", bus.m_rvalid, 2'b01);
      check_val("rbp_m_rdata", bus.m_rdata, 32'h0000_00B0 + hs);
      if (rr) hs++;
      cyc();
    end
    bus.s_rvalid = 1'b0;
    bus.s_rlast  = 1'b0;
    bus.m_rready = '0;
    #1;
    check_val("rbp_busy", busy, 0);
    check_val("rbp_len_err", len_err, 0);

    // Early rlast: arlen=3 but rlast on beat 2
    set_req(0, 16'h0500, 8'd3);
    ar_phase(0, 16'h0500, 8'd3, 1'b0);
    r_phase(0, 2);
    check_val("early_len_err", len_err, 1);
    set_req(1, 16'h0600, 8'd1);
    ar_phase(1, 16'h0600, 8'd1, 1'b0);
    r_phase(1, 2);
    check_val("early_sticky", len_err, 1);

    // Late rlast: arlen=1 but rlast on beat 3
    do_reset();
    check_val("late_pre_len_err", len_err, 0);
    set_req(0, 16'h0700, 8'd1);
    ar_phase(0, 16'h0700, 8'd1, 1'b0);
    r_phase(0, 3);
    check_val("late_len_err", len_err, 1);

    // Reset mid-burst on master1 arlen=7 (ptr is 1 after master0's burst)
    set_req(1, 16'h0800, 8'd7);
    ar_phase(1, 16'h0800, 8'd7, 1'b0);
    bus.m_rready = '1;
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = 32'h1;
    cyc();
    bus.s_rdata  = 32'h2;
    reset = 1'b1;
    cyc();
    check_val("mid_busy", busy, 0);
    check_val("mid_grant", grant, 0);
    check_val("mid_len_err", len_err, 0);
    check_val("mid_s_arvalid", bus.s_arvalid, 0);
    check_val("mid_s_rready", bus.s_rready, 0);
    check_val("mid_m_arready", bus.m_arready, 0);
    check_val("mid_m_rvalid", bus.m_rvalid, 0);
    reset = 1'b0;
    clear_inputs();
    set_req(1, 16'h0900, 8'd0);
    ar_phase(1, 16'h0900, 8'd0, 1'b0);
    r_phase(1, 1);
    check_val("post_rst_len_err", len_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one AXI4 read path (AR and R channels) between NUM_M requesting masters and one downstream slave.
- Round-robin arbitration on AR; the grant is held until the R beat carrying rlast has handshaked, so at most one read burst is outstanding.
- Counts R beats against arlen and flags length mismatches.
- Sits between testbench or DMA masters and the slave-side axi_intf read channels.

Parameters:
- NUM_M, 2, number of requesting masters (2..8).
- ADDR_WIDTH, 16, address width; default comes from the shared package.
- DATA_WIDTH, 32, data width; default comes from the shared package.
- ID_WIDTH, 8, AXI ID width; default comes from the shared package.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- m_arvalid  in  NUM_M  per-master AR valid.
- m_arready  out  NUM_M  per-master AR ready.
- m_arid  in  NUM_M*ID_WIDTH  packed per-master arid; master i occupies slice i.
- m_araddr  in  NUM_M*ADDR_WIDTH  packed per-master araddr.
- m_arlen  in  NUM_M*8  packed per-master arlen.
- m_arsize  in  NUM_M*3  packed per-master arsize.
- m_arburst  in  NUM_M*2  packed per-master arburst.
- m_rvalid  out  NUM_M  per-master R valid.
- m_rready  in  NUM_M  per-master R ready.
- m_rid  out  ID_WIDTH  R id, broadcast to all masters.
- m_rdata  out  DATA_WIDTH  R data, broadcast.
- m_rresp  out  2  R response, broadcast.
- m_rlast  out  1  R last, broadcast.
- s_arvalid  out  1  slave AR valid.
- s_arready  in  1  slave AR ready.
- s_arid  out  ID_WIDTH  slave arid.
- s_araddr  out  ADDR_WIDTH  slave araddr.
- s_arlen  out  8  slave arlen.
- s_arsize  out  3  slave arsize.
- s_arburst  out  2  slave arburst.
- s_rvalid  in  1  slave R valid.
- s_rready  out  1  slave R ready.
- s_rid  in  ID_WIDTH  slave R id.
- s_rdata  in  DATA_WIDTH  slave R data.
- s_rresp  in  2  slave R response.
- s_rlast  in  1  slave R last.
- grant  out  $clog2(NUM_M)  index of the current or last granted master.
- busy  out  1  high whenever state is not IDLE.
- len_err  out  1  sticky beat-count mismatch flag.

Behaviour:
- Reset: state=IDLE; grant=0; RR pointer=0; beat_cnt=0; len_err=0.
- Reset: s_arvalid=0, s_rready=0, m_arready=0, m_rvalid=0, busy=0.
- Reset mid-burst: abandon the burst immediately and hold all of the above values. Slave-side cleanup is not this block's job.
- States: IDLE -> ADDR -> DATA -> IDLE.
- IDLE: if any m_arvalid is set, pick the first requester at or after the RR pointer (cyclic). Register the winner into grant, load beat_cnt with that master's arlen, go to ADDR. With no request, stay in IDLE.
- ADDR:
  - s_ar* is a combinational mux of master[grant]; s_arvalid = m_arvalid[grant].
  - m_arready[grant] = s_arready; all other m_arready bits are 0.
  - On the s_arvalid && s_arready handshake, go to DATA.
  - Latency: a request seen in IDLE at cycle n produces s_arvalid=1 at n+1.
- DATA:
  - m_rvalid[grant] = s_rvalid; s_rready = m_rready[grant].
  - Non-granted m_rvalid bits are 0. m_r* payload is a broadcast of s_r*.
  - Each R handshake decrements beat_cnt.
  - Handshake with s_rlast=1: set len_err if beat_cnt!=0. Set the RR pointer to grant+1 (mod NUM_M). Go to IDLE.
  - Handshake with s_rlast=0 and beat_cnt==0: set len_err. Stay in DATA and keep routing until rlast; beat_cnt saturates at 0, no wrap.
- AXI rules:
  - The AR payload must stay stable while s_arvalid is high and unaccepted; this holds because grant is frozen in ADDR.
  - A master dropping arvalid before acceptance is a master protocol violation; the block keeps forwarding it and does not check it.
- Back-to-back: after rlast, one IDLE cycle minimum before the next AR is presented. This gives 1 bubble per burst.
- arlen=0 (single beat): DATA ends on the first handshake, which must carry rlast.
- len_err clears only on reset.

Decomposition:
- Package axi_arb_pkg holds:
  - ADDR_WIDTH, DATA_WIDTH, ID_WIDTH, STRB_WIDTH constants, shared with the interface.
  - typedef enum logic [1:0] {IDLE, ADDR, DATA} arb_state_e.
  - AXI burst/resp encodings (FIXED/INCR/WRAP; OKAY/EXOKAY/SLVERR/DECERR).
- Sub-module rr_arbiter (parameter N):
  - Inputs: req[N], ptr; output: one-hot grant and its index.
  - Purely combinational, reusable for the write-side arbiter.

Test Plan:
- Single request: master0 arvalid, araddr=0x0100, arlen=3, s_arready=1 -> s_arvalid at n+1 with araddr=0x0100. 4 beats routed to master0 only; m_rvalid[1]=0 throughout; busy falls the cycle after rlast; len_err=0.
- Simultaneous requests: both masters request continuously, arlen=0 each -> grant sequence 0,1,0,1 over 4 bursts; each master gets 2 bursts.
- AR backpressure: s_arready held 0 for 5 cycles -> s_arvalid stays 1 and s_araddr stays stable; m_arready[grant]=0 until s_arready rises; exactly one AR handshake.
- R backpressure: m_rready[grant] toggles 1,0,1,0 during an arlen=3 burst -> s_rready mirrors it; beats are not lost or duplicated; 4 handshakes total.
- Length error, early: arlen=3, slave asserts rlast on beat 2 -> len_err=1, state returns to IDLE; the next burst proceeds normally with len_err still 1.
- Length error, late: arlen=1, rlast only on beat 3 -> len_err=1; all 3 beats are forwarded.
- Reset mid-burst: assert reset during beat 2 of an arlen=7 burst -> the next cycle shows IDLE, all valids/readies 0, grant=0, len_err=0; a fresh master1 request is then granted normally.
